// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with an IF/ID pipeline latch and a one-entry skid
//   buffer. A word that returns from instruction memory while decode is
//   stalled is parked in the skid buffer so the PC can advance exactly once
//   per accepted instruction. Redirects (flush) and halt replace the IF/ID
//   contents with a bubble.
//
//   States:
//     IDLE   - one cycle after reset release, no request issued
//     FETCH  - requesting from instruction memory
//     HOLD   - skid buffer occupied, waiting for decode to free up
//     HALTED - fetching stopped until reset
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] imemaddr,
  output logic        pcEN,
  output logic        imemREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        flush,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  // IF/ID pipeline latch contents.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } ifid_t;

  // Skid buffer contents. Occupancy is implied by state == HOLD, so no
  // separate full flag is kept; leaving HOLD by any path empties it.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } skid_t;

  state_t      state_q, state_d;
  ifid_t       ifid_q, ifid_d;
  skid_t       skid_q, skid_d;
  ifid_t       bubble;
  logic [31:0] npc_fetch;
  logic        pc_en;
  logic        imem_ren;

  // PC+4 of the word currently being fetched; wraps naturally at 2^32.
  assign npc_fetch = imemaddr + 32'd4;

  // A bubble keeps the last npc so downstream sees a stable value.
  assign bubble = '{instr: NOP_WORD, npc: ifid_q.npc, valid: 1'b0};

  // Next-state, IF/ID/skid update and memory/PC handshake decode.
  // Priority on simultaneous requests is halt > flush > stall.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    ifid_d   = ifid_q;
    skid_d   = skid_q;
    pc_en    = 1'b0;
    imem_ren = 1'b0;

    case (state_q)
      IDLE: begin
        if (halt) begin
          ifid_d  = bubble;
          state_d = HALTED;
        end else begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (halt) begin
          ifid_d  = bubble;
          state_d = HALTED;
        end else begin
          imem_ren = 1'b1;
          if (flush) begin
            // Redirect: PC loads the target, same-cycle ihit data is dropped.
            pc_en  = 1'b1;
            ifid_d = bubble;
          end else if (ihit && !stall) begin
            pc_en  = 1'b1;
            ifid_d = '{instr: iload, npc: npc_fetch, valid: 1'b1};
          end else if (ihit) begin
            // Decode is busy: park the word so the PC can still advance.
            pc_en   = 1'b1;
            skid_d  = '{instr: iload, npc: npc_fetch};
            state_d = HOLD;
          end else if (!stall) begin
            ifid_d = bubble;
          end
          // ihit=0 with stall=1: hold IF/ID and keep requesting.
        end
      end

      HOLD: begin
        if (halt) begin
          ifid_d  = bubble;
          state_d = HALTED;
        end else if (flush) begin
          pc_en   = 1'b1;
          ifid_d  = bubble;
          state_d = FETCH;
        end else if (!stall) begin
          ifid_d  = '{instr: skid_q.instr, npc: skid_q.npc, valid: 1'b1};
          state_d = FETCH;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // IF/ID latch and skid buffer storage.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: the skid data is reset too; it is only a few flops and a known
    // value avoids X propagating into IF/ID if a transfer path ever misfires.
    if (!nRST) begin
      ifid_q <= '{instr: NOP_WORD, npc: 32'd0, valid: 1'b0};
      skid_q <= '{instr: 32'd0, npc: 32'd0};
    end else begin
      ifid_q <= ifid_d;
      skid_q <= skid_d;
    end
  end

  assign pcEN      = pc_en;
  assign imemREN   = imem_ren;
  assign iaddr     = imemaddr;
  assign instr_out = ifid_q.instr;
  assign npc_out   = ifid_q.npc;
  assign valid_out = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed testbench for fetch_stage. Inputs change 1 time unit after a
//   rising edge; combinational outputs are sampled 1 unit later and registered
//   outputs 1 unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hBAD0BAD0;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] imemaddr;
  logic        pcEN;
  logic        imemREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        stall;
  logic        flush;
  logic        halt;
  logic [31:0] instr_out;
  logic [31:0] npc_out;
  logic        valid_out;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_stage #(.NOP_WORD(NOP)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemaddr  (imemaddr),
    .pcEN      (pcEN),
    .imemREN   (imemREN),
    .iaddr     (iaddr),
    .ihit      (ihit),
    .iload     (iload),
    .stall     (stall),
    .flush     (flush),
    .halt      (halt),
    .instr_out (instr_out),
    .npc_out   (npc_out),
    .valid_out (valid_out)
  );

  always #5 CLK = ~CLK;

  // Advance past the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Apply inputs, then wait for combinational outputs to settle.
  task automatic drive(input logic [31:0] addr, input logic hit, input logic [31:0] word,
                       input logic st, input logic fl, input logic hl);
    imemaddr = addr; ihit = hit; iload = word; stall = st; flush = fl; halt = hl;
    #1;
  endtask

  // Reset with release between edges, leaving the DUT in FETCH.
  task automatic do_reset();
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    nRST = 1'b0;
    #12;
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive(32'h00000040, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    #7;
    tests_run++; if (instr_out !== NOP) begin tests_failed++; $display("FAIL rst_instr: got %h want %h", instr_out, NOP); end
    tests_run++; if (npc_out !== 32'h0) begin tests_failed++; $display("FAIL rst_npc: got %h want %h", npc_out, 32'h0); end
    tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", valid_out); end
    tests_run++; if (imemREN !== 1'b0) begin tests_failed++; $display("FAIL rst_ren: got %b want 0", imemREN); end
    tests_run++; if (pcEN !== 1'b0) begin tests_failed++; $display("FAIL rst_pcen: got %b want 0", pcEN); end
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    tests_run++; if (imemREN !== 1'b0) begin tests_failed++; $display("FAIL idle_ren: got %b want 0", imemREN); end
    tests_run++; if (pcEN !== 1'b0) begin tests_failed++; $display("FAIL idle_pcen: got %b want 0", pcEN); end
    step();
    drive(32'h00000040, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (imemREN !== 1'b1) begin tests_failed++; $display("FAIL fetch_ren: got %b want 1", imemREN); end
    tests_run++; if (iaddr !== 32'h00000040) begin tests_failed++; $display("FAIL iaddr: got %h want %h", iaddr, 32'h00000040); end
  endtask

  task automatic test_hit();
    drive(32'h00000040, 1'b1, 32'h8C220004, 1'b0, 1'b0, 1'b0);
    tests_run++; if (pcEN !== 1'b1) begin tests_failed++; $display("FAIL hit_pcen: got %b want 1", pcEN); end
    step();
    tests_run++; if (instr_out !== 32'h8C220004) begin tests_failed++; $display("FAIL hit_instr: got %h want %h", instr_out, 32'h8C220004); end
    tests_run++; if (npc_out !== 32'h00000044) begin tests_failed++; $display("FAIL hit_npc: got %h want %h", npc_out, 32'h00000044); end
    tests_run++; if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL hit_valid: got %b want 1", valid_out); end
    // Miss without stall: bubble, npc kept.
    drive(32'h00000044, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    tests_run++; if (pcEN !== 1'b0) begin tests_failed++; $display("FAIL miss_pcen: got %b want 0", pcEN); end
    step();
    tests_run++; if (instr_out !== NOP) begin tests_failed++; $display("FAIL miss_instr: got %h want %h", instr_out, NOP); end
    tests_run++; if (npc_out !== 32'h00000044) begin tests_failed++; $display("FAIL miss_npc: got %h want %h", npc_out, 32'h00000044); end
    tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL miss_valid: got %b want 0", valid_out); end
    // Hit, then miss with stall: IF/ID held, still requesting.
    drive(32'h00000100, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
    step();
    drive(32'h00000104, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tests_run++; if (imemREN !== 1'b1) begin tests_failed++; $display("FAIL missst_ren: got %b want 1", imemREN); end
    tests_run++; if (pcEN !== 1'b0) begin tests_failed++; $display("FAIL missst_pcen: got %b want 0", pcEN); end
    step();
    tests_run++; if (instr_out !== 32'h11111111) begin tests_failed++; $display("FAIL missst_instr: got %h want %h", instr_out, 32'h11111111); end
    tests_run++; if (npc_out !== 32'h00000104) begin tests_failed++; $display("FAIL missst_npc: got %h want %h", npc_out, 32'h00000104); end
    tests_run++; if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL missst_valid: got %b want 1", valid_out); end
  endtask

  task automatic test_skid();
    int pulses = 0;
    // Cycle 1: hit while stalled -> single pcEN pulse, word parked.
    drive(32'h00000200, 1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0);
    if (pcEN === 1'b1) pulses++;
    step();
    // Cycles 2 and 3: HOLD, new ihit data must be ignored.
    for (int i = 0; i < 2; i++) begin
      drive(32'h00000204, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0);
      if (pcEN === 1'b1) pulses++;
      tests_run++; if (imemREN !== 1'b0) begin tests_failed++; $display("FAIL hold_ren[%0d]: got %b want 0", i, imemREN); end
      step();
      tests_run++; if (instr_out !== 32'h11111111 || valid_out !== 1'b1) begin
        tests_failed++; $display("FAIL hold_ifid[%0d]: got %h/%b want %h/1", i, instr_out, valid_out, 32'h11111111);
      end
    end
    tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL skid_pulses: got %0d want 1", pulses); end
    // Stall released: buffered word lands in IF/ID.
    drive(32'h00000204, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (pcEN !== 1'b0 || imemREN !== 1'b0) begin tests_failed++; $display("FAIL drain_hs: got pcEN=%b ren=%b want 0/0", pcEN, imemREN); end
    step();
    tests_run++; if (instr_out !== 32'h22222222) begin tests_failed++; $display("FAIL drain_instr: got %h want %h", instr_out, 32'h22222222); end
    tests_run++; if (npc_out !== 32'h00000204) begin tests_failed++; $display("FAIL drain_npc: got %h want %h", npc_out, 32'h00000204); end
    tests_run++; if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL drain_valid: got %b want 1", valid_out); end
    tests_run++; if (imemREN !== 1'b1) begin tests_failed++; $display("FAIL drain_ren: got %b want 1", imemREN); end
  endtask

  task automatic test_flush();
    // Enter HOLD with a parked word, then flush it away.
    drive(32'h00000300, 1'b1, 32'h44444444, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h00000304, 1'b1, 32'h45454545, 1'b1, 1'b1, 1'b0);
    tests_run++; if (pcEN !== 1'b1) begin tests_failed++; $display("FAIL flhold_pcen: got %b want 1", pcEN); end
    step();
    tests_run++; if (instr_out !== NOP || valid_out !== 1'b0) begin tests_failed++; $display("FAIL flhold_ifid: got %h/%b want %h/0", instr_out, valid_out, NOP); end
    tests_run++; if (npc_out !== 32'h00000204) begin tests_failed++; $display("FAIL flhold_npc: got %h want %h", npc_out, 32'h00000204); end
    drive(32'h00000800, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (imemREN !== 1'b1) begin tests_failed++; $display("FAIL flhold_ren: got %b want 1", imemREN); end
    step();
    tests_run++; if (instr_out === 32'h44444444 || valid_out !== 1'b0) begin tests_failed++; $display("FAIL flhold_gone: got %h/%b want %h/0", instr_out, valid_out, NOP); end
    // Flush in FETCH with a same-cycle hit: hit data dropped.
    drive(32'h00000400, 1'b1, 32'h55555555, 1'b0, 1'b0, 1'b0);
    step();
    drive(32'h00000404, 1'b1, 32'h56565656, 1'b0, 1'b1, 1'b0);
    tests_run++; if (pcEN !== 1'b1) begin tests_failed++; $display("FAIL flfetch_pcen: got %b want 1", pcEN); end
    step();
    tests_run++; if (instr_out !== NOP || valid_out !== 1'b0) begin tests_failed++; $display("FAIL flfetch_ifid: got %h/%b want %h/0", instr_out, valid_out, NOP); end
    tests_run++; if (npc_out !== 32'h00000404) begin tests_failed++; $display("FAIL flfetch_npc: got %h want %h", npc_out, 32'h00000404); end
  endtask

  task automatic test_wrap();
    drive(32'hFFFFFFFC, 1'b1, 32'h66666666, 1'b0, 1'b0, 1'b0);
    step();
    tests_run++; if (npc_out !== 32'h00000000 || instr_out !== 32'h66666666) begin
      tests_failed++; $display("FAIL wrap: got %h/%h want %h/%h", npc_out, instr_out, 32'h0, 32'h66666666);
    end
  endtask

  task automatic test_reset_in_hold();
    drive(32'h00000500, 1'b1, 32'h77777777, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h00000504, 1'b1, 32'h78787878, 1'b1, 1'b0, 1'b0);
    #1;
    nRST = 1'b0;
    #1;
    tests_run++; if (instr_out !== NOP || npc_out !== 32'h0 || valid_out !== 1'b0) begin
      tests_failed++; $display("FAIL arst_ifid: got %h/%h/%b want %h/0/0", instr_out, npc_out, valid_out, NOP);
    end
    tests_run++; if (imemREN !== 1'b0 || pcEN !== 1'b0) begin tests_failed++; $display("FAIL arst_hs: got ren=%b pcEN=%b want 0/0", imemREN, pcEN); end
    #1;
    nRST = 1'b1;
    drive(32'h00000000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (imemREN !== 1'b0) begin tests_failed++; $display("FAIL arst_idle_ren: got %b want 0", imemREN); end
    step();
    tests_run++; if (imemREN !== 1'b1) begin tests_failed++; $display("FAIL arst_first_ren: got %b want 1", imemREN); end
    step();
    tests_run++; if (instr_out !== NOP || valid_out !== 1'b0) begin tests_failed++; $display("FAIL arst_skid_gone: got %h/%b want %h/0", instr_out, valid_out, NOP); end
  endtask

  task automatic test_halt();
    drive(32'h00000600, 1'b1, 32'h99999999, 1'b0, 1'b0, 1'b0);
    step();
    drive(32'h00000604, 1'b1, 32'h88888888, 1'b0, 1'b1, 1'b1);
    tests_run++; if (pcEN !== 1'b0 || imemREN !== 1'b0) begin tests_failed++; $display("FAIL halt_hs: got pcEN=%b ren=%b want 0/0", pcEN, imemREN); end
    step();
    tests_run++; if (valid_out !== 1'b0 || instr_out !== NOP) begin tests_failed++; $display("FAIL halt_ifid: got %h/%b want %h/0", instr_out, valid_out, NOP); end
    for (int i = 0; i < 10; i++) begin
      drive(32'h00000604 + 32'(i * 4), 1'b1, 32'hAAAA0000 + 32'(i), 1'b0, i[0], 1'b0);
      tests_run++; if (imemREN !== 1'b0 || pcEN !== 1'b0) begin
        tests_failed++; $display("FAIL halted_hs[%0d]: got ren=%b pcEN=%b want 0/0", i, imemREN, pcEN);
      end
      step();
      tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL halted_valid[%0d]: got %b want 0", i, valid_out); end
    end
    // Reset is the only way out of HALTED.
    do_reset();
    drive(32'h00000700, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (imemREN !== 1'b1) begin tests_failed++; $display("FAIL unhalt_ren: got %b want 1", imemREN); end
  endtask

  initial begin
    nRST = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_hit();
    test_skid();
    test_flush();
    test_wrap();
    test_reset_in_hold();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
